gray_updown_counter: RTL and testbench

Parametrised up/down Gray-code counter. It holds a binary count register and a registered Gray-coded copy of it. The Gray output changes exactly one bit per counting step and is free of combinational glitches. Intended for pointer generation in clock-domain-crossing FIFOs and for position encoders. It supports enable, direction, synchronous clear, Gray-coded parallel load, and a wrap or saturate mode.

---
 rtl/gray_updown_counter.sv | 79 +++++++
 tb/tb_gray_updown_counter.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/gray_updown_counter.sv
// Up/down Gray-code counter with enable, synchronous clear, Gray-coded
// parallel load and wrap/saturate end behaviour. Binary and Gray copies
// are both registered, so gray_out is glitch-free.
module gray_updown_counter #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_gray,
  output logic [WIDTH-1:0] bin_out,
  output logic [WIDTH-1:0] gray_out,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] load_bin;
  logic [WIDTH-1:0] bin_nxt;
  logic [WIDTH-1:0] gray_nxt;
  logic             wrap_nxt;

  // Terminal count: at the end of the range in the current direction.
  always_comb begin
    tc = (!dir && (bin_out == '1)) || (dir && (bin_out == '0));
  end

  // Gray-to-binary conversion of the load value, MSB downwards.
  always_comb begin
    load_bin = '0;
    load_bin[WIDTH-1] = load_gray[WIDTH-1];
    for (int unsigned k = 1; k < WIDTH; k++) begin
      load_bin[WIDTH-1-k] = load_bin[WIDTH-k] ^ load_gray[WIDTH-1-k];
    end
  end

  // Next-state selection: clr > load > en > hold.
  always_comb begin
    bin_nxt  = bin_out;
    gray_nxt = gray_out;
    wrap_nxt = 1'b0;
    if (clr) begin
      bin_nxt  = '0;
      gray_nxt = '0;
    end else if (load) begin
      bin_nxt  = load_bin;
      gray_nxt = load_gray;
    end else if (en) begin
      if (tc) begin
        if (SATURATE == 0) begin
          bin_nxt  = dir ? '1 : '0;
          wrap_nxt = 1'b1;
        end
      end else begin
        bin_nxt = dir ? (bin_out - ONE) : (bin_out + ONE);
      end
      gray_nxt = bin_nxt ^ (bin_nxt >> 1);
    end
  end

  // Count, Gray and wrap registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bin_out  <= '0;
      gray_out <= '0;
      wrap     <= 1'b0;
    end else begin
      bin_out  <= bin_nxt;
      gray_out <= gray_nxt;
      wrap     <= wrap_nxt;
    end
  end

endmodule

// File: tb/tb_gray_updown_counter.sv
// Bench for gray_updown_counter: a wrapping and a saturating instance
// share stimulus; an integer model predicts both, checked every cycle.
module tb_gray_updown_counter;

  localparam int MAX = 15;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0, dir = 1'b0, clr = 1'b0, load = 1'b0;
  logic [3:0] lg = '0;

  logic [3:0] bin_o [2];
  logic [3:0] gray_o[2];
  logic       tc_o  [2];
  logic       wrap_o[2];

  int vectors = 0;
  int miscompares = 0;

  // Model state: count, expected wrap, step kind (0 exempt, 1 move, 2 hold).
  int m [2] = '{0, 0};
  int mw[2] = '{0, 0};
  int mk[2] = '{0, 0};
  int prev_g[2] = '{0, 0};

  int up_tab[17] = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8, 0};

  always #5 clk = ~clk;

  gray_updown_counter #(.WIDTH(4), .SATURATE(0)) dut_wrap (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .clr(clr), .load(load),
    .load_gray(lg), .bin_out(bin_o[0]), .gray_out(gray_o[0]),
    .tc(tc_o[0]), .wrap(wrap_o[0])
  );

  gray_updown_counter #(.WIDTH(4), .SATURATE(1)) dut_sat (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .clr(clr), .load(load),
    .load_gray(lg), .bin_out(bin_o[1]), .gray_out(gray_o[1]),
    .tc(tc_o[1]), .wrap(wrap_o[1])
  );

  task automatic chk(string name, int act, int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Search for the binary value whose Gray code matches.
  function automatic int g2b(int g);
    for (int b = 0; b <= MAX; b++) if ((b ^ (b >> 1)) == g) return b;
    return -1;
  endfunction

  // Reference model.
  always @(posedge clk or negedge rst) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst) begin
        m[i] <= 0; mw[i] <= 0; mk[i] <= 0;
      end else if (clr) begin
        m[i] <= 0; mw[i] <= 0; mk[i] <= 0;
      end else if (load) begin
        m[i] <= g2b(int'(lg)); mw[i] <= 0; mk[i] <= 0;
      end else if (en) begin
        if ((!dir && m[i] == MAX) || (dir && m[i] == 0)) begin
          if (i == 1) begin
            mw[i] <= 0; mk[i] <= 2;
          end else begin
            m[i] <= dir ? MAX : 0; mw[i] <= 1; mk[i] <= 1;
          end
        end else begin
          m[i] <= dir ? m[i] - 1 : m[i] + 1; mw[i] <= 0; mk[i] <= 1;
        end
      end else begin
        mw[i] <= 0; mk[i] <= 2;
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      chk("bin", int'(bin_o[i]), m[i]);
      chk("gray", int'(gray_o[i]), m[i] ^ (m[i] >> 1));
      chk("gray_inv", int'(gray_o[i]), int'(bin_o[i] ^ (bin_o[i] >> 1)));
      chk("wrap", int'(wrap_o[i]), mw[i]);
      chk("tc", int'(tc_o[i]), dir ? int'(m[i] == 0) : int'(m[i] == MAX));
      if (mk[i] != 0)
        chk("adjacent", $countones(int'(gray_o[i]) ^ prev_g[i]), (mk[i] == 1) ? 1 : 0);
      prev_g[i] <= int'(gray_o[i]);
    end
  end

  task automatic drive(bit e, bit d, bit c, bit l, logic [3:0] g);
    en = e; dir = d; clr = c; load = l; lg = g;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1 rst = 1'b0;
    tick(); tick();
    chk("reset_bin", int'(bin_o[0]), 0);
    chk("reset_gray", int'(gray_o[0]), 0);
    chk("reset_wrap", int'(wrap_o[0]), 0);
    rst = 1'b1;

    // Full up-count with wrap.
    drive(1, 0, 0, 0, 4'h0);
    for (int k = 1; k <= 16; k++) begin
      tick();
      chk("up_gray", int'(gray_o[0]), up_tab[k]);
      chk("up_wrap", int'(wrap_o[0]), (k == 16) ? 1 : 0);
      if (k == 15) chk("tc_at_F", int'(tc_o[0]), 1);
      if (k >= 15) chk("sat_bin", int'(bin_o[1]), 15);
    end
    for (int j = 0; j < 2; j++) begin
      tick();
      chk("sat_bin", int'(bin_o[1]), 15);
      chk("sat_gray", int'(gray_o[1]), 8);
      chk("sat_wrap", int'(wrap_o[1]), 0);
      chk("sat_tc", int'(tc_o[1]), 1);
    end

    // Down-count through 0.
    drive(0, 0, 1, 0, 4'h0);
    tick();
    chk("clr_bin", int'(bin_o[0]), 0);
    drive(1, 1, 0, 0, 4'h0);
    tick();
    chk("down_bin1", int'(bin_o[0]), 15);
    chk("down_gray1", int'(gray_o[0]), 8);
    chk("down_wrap1", int'(wrap_o[0]), 1);
    tick();
    chk("down_bin2", int'(bin_o[0]), 14);
    chk("down_gray2", int'(gray_o[0]), 9);
    chk("down_wrap2", int'(wrap_o[0]), 0);

    // Load has priority over en.
    drive(1, 0, 0, 1, 4'hD);
    tick();
    chk("load_bin", int'(bin_o[0]), 9);
    chk("load_gray", int'(gray_o[0]), 13);
    drive(1, 0, 0, 0, 4'h0);
    tick();
    chk("after_load_bin", int'(bin_o[0]), 10);
    chk("after_load_gray", int'(gray_o[0]), 15);

    // clr beats load and en.
    drive(0, 0, 0, 1, 4'h7);
    tick();
    chk("load5_bin", int'(bin_o[0]), 5);
    drive(1, 0, 1, 1, 4'hB);
    tick();
    chk("clr_pri_bin", int'(bin_o[0]), 0);
    chk("clr_pri_gray", int'(gray_o[0]), 0);

    // Asynchronous reset between edges.
    drive(0, 0, 0, 1, 4'h4);
    tick();
    chk("load7_bin", int'(bin_o[0]), 7);
    drive(0, 0, 0, 0, 4'h0);
    #1 rst = 1'b0;
    #1;
    chk("async_bin", int'(bin_o[0]), 0);
    chk("async_gray", int'(gray_o[0]), 0);
    chk("async_wrap", int'(wrap_o[0]), 0);
    #1 rst = 1'b1;
    drive(1, 1, 0, 0, 4'h0);
    tick();
    chk("first_down_wrap", int'(bin_o[0]), 15);
    chk("first_down_sat", int'(bin_o[1]), 0);

    // Randomised traffic.
    for (int n = 0; n < 3000; n++) begin
      drive(($urandom % 8) != 0, $urandom % 2, ($urandom % 32) == 0,
            ($urandom % 16) == 0, 4'($urandom));
      tick();
      if (($urandom % 200) == 0) begin
        #1 rst = 1'b0;
        #1 rst = 1'b1;
      end
    end

    drive(0, 0, 0, 0, 4'h0);
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
